clock_display_mux: RTL and testbench

Downstream display stage for the hours/minutes/seconds counter. It captures the binary time fields on a load strobe and converts each field to two BCD digits. It drives a six-digit, time-multiplexed seven-segment display (HH.MM.SS) with a programmable scan rate, ghost blanking and optional hours leading-zero suppression. Same clock domain as the counter; the counter's advance strobe is wired to `load`.

---
 rtl/clock_disp_pkg.sv | 44 ++++
 rtl/bin2bcd_2d.sv | 29 ++
 rtl/clock_display_mux.sv | 108 ++++++++++
 tb/tb_clock_display_mux.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants and helpers for the multiplexed HH.MM.SS seven-segment display.
package clock_disp_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam int NUM_DIGITS = 6;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] HR_MAX  = 6'd23;

  // Segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational 6-bit binary to two BCD digits, flagging values above a supplied maximum.
module bin2bcd_2d (
  input  logic [5:0] bin,
  input  logic [5:0] max,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       ovf
);

  logic [5:0] rem;
  logic [3:0] tens_acc;

  // Six compare/subtract stages cover the full 0..63 input range.
  always_comb begin
    rem      = bin;
    tens_acc = 4'd0;
    for (int k = 0; k < 6; k++) begin
      if (rem >= 6'd10) begin
        rem      = rem - 6'd10;
        tens_acc = tens_acc + 4'd1;
      end
    end
  end

  assign tens  = tens_acc;
  assign units = rem[3:0];
  assign ovf   = (bin > max);

endmodule

// File: rtl/clock_display_mux.sv
// Snapshots the time fields and scans them onto a six-digit multiplexed seven-segment display.
module clock_display_mux
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic       load,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int PCNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [5:0]        snap_sec;
  logic [5:0]        snap_min;
  logic [4:0]        snap_hr;
  logic [PCNT_W-1:0] pcnt;
  digit_idx_t        idx;
  digit_idx_t        idx_next;
  logic              tc;

  logic [5:0]        field_val [3];
  logic [3:0]        tens      [3];
  logic [3:0]        units     [3];
  logic [2:0]        ovf;

  logic [5:0]        onehot;
  logic [1:0]        sel;
  logic [3:0]        digit;
  logic [6:0]        seg_next;
  logic              dp_next;
  logic [5:0]        an_next;

  assign tc       = (pcnt == PCNT_W'(SCAN_DIV - 1));
  assign idx_next = tc ? ((idx == digit_idx_t'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1) : idx;

  assign field_val[0] = snap_sec;
  assign field_val[1] = snap_min;
  assign field_val[2] = {1'b0, snap_hr};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
      bin2bcd_2d u_bcd (
        .bin   (field_val[gi]),
        .max   ((gi == 2) ? HR_MAX : ((gi == 1) ? MIN_MAX : SEC_MAX)),
        .tens  (tens[gi]),
        .units (units[gi]),
        .ovf   (ovf[gi])
      );
    end
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign onehot[gi] = (idx_next == digit_idx_t'(gi));
    end
  endgenerate

  // Outputs are built from the index about to be current, so the ghost cycle already carries the new digit.
  always_comb begin
    sel      = idx_next[2:1];
    digit    = 4'd0;
    seg_next = SEG_BLANK;
    case (sel)
      2'd0:    digit = idx_next[0] ? tens[0] : units[0];
      2'd1:    digit = idx_next[0] ? tens[1] : units[1];
      default: digit = idx_next[0] ? tens[2] : units[2];
    endcase
    if (ovf[(sel > 2'd2) ? 2'd2 : sel]) begin
      seg_next = SEG_DASH;
    end else if ((LZ_BLANK != 0) && (idx_next == 3'd5) && (tens[2] == 4'd0)) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = seg_of(digit);
    end
    dp_next = ((idx_next == 3'd2) || (idx_next == 3'd4)) && !snap_sec[0];
    an_next = tc ? 6'd0 : onehot;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_sec <= '0;
      snap_min <= '0;
      snap_hr  <= '0;
      pcnt     <= '0;
      idx      <= '0;
      seg      <= '0;
      dp       <= 1'b0;
      an       <= '0;
    end else begin
      if (load) begin
        snap_sec <= sec;
        snap_min <= min;
        snap_hr  <= hr;
      end
      pcnt <= tc ? '0 : pcnt + PCNT_W'(1);
      idx  <= idx_next;
      seg  <= seg_next;
      dp   <= dp_next;
      an   <= an_next;
    end
  end

endmodule

// File: tb/tb_clock_display_mux.sv
// Directed bench for clock_display_mux with a cycle-accurate scoreboard of expected display outputs.
module tb_clock_display_mux;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hr = '0;
  logic       load = 1'b0;
  logic [6:0] seg, seg_nolz;
  logic       dp, dp_nolz;
  logic [5:0] an, an_nolz;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int m_sec = 0, m_min = 0, m_hr = 0;

  typedef struct {
    int         idx;
    logic [6:0] seg;
    logic [6:0] seg_nolz;
    logic       dp;
    logic [5:0] an;
  } exp_t;

  exp_t sb[$];

  logic [6:0] lit_seg [6];
  logic [6:0] lit_nolz[6];
  logic       lit_dp  [6];

  clock_display_mux #(.SCAN_DIV(SD), .LZ_BLANK(1)) dut (
    .clk(clk), .reset_n(reset_n), .sec(sec), .min(min), .hr(hr), .load(load),
    .seg(seg), .dp(dp), .an(an)
  );

  clock_display_mux #(.SCAN_DIV(SD), .LZ_BLANK(0)) dut_nolz (
    .clk(clk), .reset_n(reset_n), .sec(sec), .min(min), .hr(hr), .load(load),
    .seg(seg_nolz), .dp(dp_nolz), .an(an_nolz)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int s, input int m, input int h, input int ix, input bit lz);
    int val, mx;
    case (ix / 2)
      0:       begin val = s; mx = 59; end
      1:       begin val = m; mx = 59; end
      default: begin val = h; mx = 23; end
    endcase
    if (val > mx) return 7'h40;
    if (lz && ix == 5 && (val / 10) == 0) return 7'h00;
    return digit_code((ix % 2) ? (val / 10) : (val % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: push the expectation for this edge, apply it, then pop and compare.
  task automatic tick();
    exp_t ex, got;
    int e;
    e           = ecnt + 1;
    ex.idx      = (e / SD) % 6;
    ex.an       = (e % SD == 0) ? 6'd0 : 6'(1 << ex.idx);
    ex.seg      = model_seg(m_sec, m_min, m_hr, ex.idx, 1'b1);
    ex.seg_nolz = model_seg(m_sec, m_min, m_hr, ex.idx, 1'b0);
    ex.dp       = ((ex.idx == 2 || ex.idx == 4) && (m_sec % 2 == 0)) ? 1'b1 : 1'b0;
    sb.push_back(ex);
    if (load) begin
      m_sec = int'(sec);
      m_min = int'(min);
      m_hr  = int'(hr);
    end
    @(posedge clk);
    #1;
    ecnt = e;
    got = sb.pop_front();
    check("seg", 32'(seg), 32'(got.seg));
    check("seg_nolz", 32'(seg_nolz), 32'(got.seg_nolz));
    check("dp", 32'(dp), 32'(got.dp));
    check("an", 32'(an), 32'(got.an));
    $display("edge %0d idx %0d an=%b seg=%h dp=%b seg_nolz=%h", e, got.idx, an, seg, dp, seg_nolz);
    if (got.an != 6'd0) begin
      lit_seg[got.idx]  = seg;
      lit_nolz[got.idx] = seg_nolz;
      lit_dp[got.idx]   = dp;
    end
  endtask

  task automatic load_time(input int h, input int m, input int s);
    hr   = 5'(h);
    min  = 6'(m);
    sec  = 6'(s);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance until the next edge starts a frame, then scan one full frame.
  task automatic run_frame();
    while (ecnt % (6 * SD) != 6 * SD - 1) tick();
    for (int i = 0; i < 6; i++) begin
      lit_seg[i]  = 'x;
      lit_nolz[i] = 'x;
      lit_dp[i]   = 1'bx;
    end
    for (int i = 0; i < 6 * SD; i++) tick();
  endtask

  logic [6:0] tbl_2359 [6];

  initial begin
    tbl_2359 = '{7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h4F, 7'h5B};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'h0);
    check("rst_an", 32'(an), 32'h0);
    check("rst_dp", 32'(dp), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 23:59:59 captured on the very first edge
    load_time(23, 59, 59);
    check("first_an", 32'(an), 32'h01);
    check("first_seg", 32'(seg), 32'h3F);
    run_frame();
    for (int i = 0; i < 6; i++) begin
      check("frame2359_seg", 32'(lit_seg[i]), 32'(tbl_2359[i]));
      check("frame2359_dp", 32'(lit_dp[i]), 32'h0);
    end

    // 05:07:08 with and without leading-zero blanking
    load_time(5, 7, 8);
    run_frame();
    check("lz_blank_idx5", 32'(lit_seg[5]), 32'h00);
    check("hr_units_idx4", 32'(lit_seg[4]), 32'h6D);
    check("min_units_idx2", 32'(lit_seg[2]), 32'h07);
    check("dp_idx2", 32'(lit_dp[2]), 32'h1);
    check("nolz_idx5", 32'(lit_nolz[5]), 32'h3F);

    // Out-of-range fields show dashes
    load_time(24, 61, 60);
    run_frame();
    for (int i = 0; i < 6; i++) check("dash", 32'(lit_seg[i]), 32'h40);

    // Load on the terminal-count edge that moves the scan to idx 0
    while (ecnt % (6 * SD) != 6 * SD - 1) tick();
    load_time(12, 34, 56);
    tick();
    check("tc_load_an", 32'(an), 32'h01);
    check("tc_load_seg", 32'(seg), 32'h7D);
    run_frame();

    // load held high while sec ramps
    load = 1'b1;
    for (int s = 0; s < 60; s++) begin
      sec = 6'(s);
      tick();
    end
    load = 1'b0;
    tick();

    // Asynchronous reset in the middle of a lit slot
    while (ecnt % SD != 2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_seg", 32'(seg), 32'h0);
    check("async_an", 32'(an), 32'h0);
    check("async_dp", 32'(dp), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ecnt = 0;
    m_sec = 0;
    m_min = 0;
    m_hr = 0;
    sb.delete();
    tick();
    check("restart_an", 32'(an), 32'h01);
    check("restart_seg", 32'(seg), 32'h3F);
    repeat (SD) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
